utopia_rx_scheduler: RTL and testbench

Cell-level round-robin scheduler for `NumRx` UTOPIA receive ports feeding a single core cell input. It polls each port's `clav`, grants one port at a time by driving that port's active-low enable for exactly one cell, and forwards the received bytes to the core. Every forwarded byte carries a port tag and a start-of-cell flag. It sits between the PHY-side receive ports and the core receive logic, and replaces per-port enable handling.

---
 rtl/utopia_rx_if.sv | 44 ++++
 rtl/utopia_rx_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_utopia_rx_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/utopia_rx_if.sv
// ---------------------------------------------------------------------------
// utopia_rx_if
// Bundles the PHY-side UTOPIA receive signals and the core-side cell output
// of the receive scheduler.
//   rx_clav    per-port cell available (PHY -> scheduler)
//   rx_soc     per-port start of cell (PHY -> scheduler)
//   rx_data    per-port byte lane, port p at [p*IfWidth +: IfWidth]
//   rx_en_n    per-port active-low read enable (scheduler -> PHY)
//   core_ready core can take a full cell (core -> scheduler)
//   out_*      forwarded byte with tag, start flag, cell end and error pulses
//   busy       grant in progress
// Modports: master = scheduler, slave = PHY/core environment.
// ---------------------------------------------------------------------------
interface utopia_rx_if #(
    parameter int NumRx   = 4,
    parameter int IfWidth = 8
);
    localparam int PortW = $clog2(NumRx);

    logic [NumRx-1:0]         rx_clav;
    logic [NumRx-1:0]         rx_soc;
    logic [NumRx*IfWidth-1:0] rx_data;
    logic [NumRx-1:0]         rx_en_n;
    logic                     core_ready;
    logic                     out_valid;
    logic                     out_soc;
    logic [IfWidth-1:0]       out_data;
    logic [PortW-1:0]         out_port;
    logic                     cell_done;
    logic                     cell_err;
    logic                     busy;

    modport master (
        input  rx_clav, rx_soc, rx_data, core_ready,
        output rx_en_n, out_valid, out_soc, out_data, out_port,
               cell_done, cell_err, busy
    );

    modport slave (
        output rx_clav, rx_soc, rx_data, core_ready,
        input  rx_en_n, out_valid, out_soc, out_data, out_port,
               cell_done, cell_err, busy
    );
endinterface

// File: rtl/utopia_rx_scheduler.sv
// ---------------------------------------------------------------------------
// utopia_rx_scheduler
// Cell-level round-robin scheduler for NumRx UTOPIA receive ports. In IDLE
// it picks the first port with clav set (starting at the round-robin
// pointer) when the core is ready, then holds that port's enable low for
// exactly CellBytes cycles. Each enabled cycle carries a (port, index) tag
// one cycle forward so the PHY byte arriving a cycle later is forwarded
// with its own source port, a start flag derived from the index, and a
// framing check against the PHY start-of-cell.
// Ports:
//   clk_in   rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      utopia_rx_if master modport (PHY side, core side, status)
// ---------------------------------------------------------------------------
module utopia_rx_scheduler #(
    parameter int NumRx     = 4,
    parameter int IfWidth   = 8,
    parameter int CellBytes = 53
) (
    input  logic        clk_in,
    input  logic        reset_n,
    utopia_rx_if.master bus
);
    localparam int PortW  = $clog2(NumRx);
    localparam int PortW1 = PortW + 1;
    localparam int CntW   = $clog2(CellBytes);
    localparam logic [CntW-1:0] LastIdx = CntW'(CellBytes - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PortW-1:0]     ptr_r;
    logic [PortW-1:0]     sel_r;
    logic [PortW-1:0]     pick_s;
    logic [PortW-1:0]     sel_nxt_s;
    logic [PortW1-1:0]    cand_s;
    logic                 pick_valid_s;
    logic                 grant_s;
    logic [CntW-1:0]      cnt_r;
    logic [NumRx-1:0]     en_n_nxt_s;
    logic [NumRx-1:0]     rx_en_n_r;
    logic                 busy_nxt_s;
    logic                 busy_r;

    logic                 tag_valid_r;
    logic [PortW-1:0]     tag_port_r;
    logic [CntW-1:0]      tag_idx_r;
    logic [IfWidth-1:0]   cap_data_s;
    logic                 cap_soc_s;
    logic                 err_now_s;
    logic                 err_acc_s;
    logic                 err_r;

    logic                 out_valid_r;
    logic                 out_soc_r;
    logic [IfWidth-1:0]   out_data_r;
    logic [PortW-1:0]     out_port_r;
    logic                 cell_done_r;
    logic                 cell_err_r;

    // Next round-robin position, wrapping NumRx-1 back to port 0.
    function automatic logic [PortW-1:0] wrap_inc(input logic [PortW-1:0] p);
        return (p == PortW'(NumRx - 1)) ? {PortW{1'b0}} : p + PortW'(1'b1);
    endfunction

    // Round-robin search: walk from ptr upward (mod NumRx); iterating from the
    // far end down lets the closest requester overwrite earlier hits.
    always_comb begin
        pick_s       = ptr_r;
        pick_valid_s = 1'b0;
        cand_s       = {PortW1{1'b0}};
        for (int i = NumRx - 1; i >= 0; i--) begin
            cand_s       = {1'b0, ptr_r} + PortW1'(i);
            cand_s       = (cand_s >= PortW1'(NumRx)) ? cand_s - PortW1'(NumRx) : cand_s;
            pick_s       = bus.rx_clav[cand_s[PortW-1:0]] ? cand_s[PortW-1:0] : pick_s;
            pick_valid_s = pick_valid_s | bus.rx_clav[cand_s[PortW-1:0]];
        end
    end

    // Next-state logic; clav and core_ready are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.core_ready && pick_valid_s) begin
                    state_nxt_s = XFER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            XFER: begin
                if (cnt_r == LastIdx) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = XFER;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the next state so enables and busy can be registered.
    always_comb begin
        grant_s    = (state_r == IDLE) && (state_nxt_s == XFER);
        sel_nxt_s  = grant_s ? pick_s : sel_r;
        en_n_nxt_s = (state_nxt_s == XFER) ? ~(NumRx'(1'b1) << sel_nxt_s) : {NumRx{1'b1}};
        busy_nxt_s = (state_nxt_s == XFER);
    end

    // State register, grant bookkeeping, byte counter and registered enables.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            ptr_r     <= {PortW{1'b0}};
            sel_r     <= {PortW{1'b0}};
            cnt_r     <= {CntW{1'b0}};
            rx_en_n_r <= {NumRx{1'b1}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            sel_r     <= sel_nxt_s;
            rx_en_n_r <= en_n_nxt_s;
            busy_r    <= busy_nxt_s;
            if (grant_s) begin
                ptr_r <= wrap_inc(pick_s);
                cnt_r <= {CntW{1'b0}};
            end else if (state_r == XFER && state_nxt_s == XFER) begin
                cnt_r <= cnt_r + CntW'(1'b1);
            end else begin
                cnt_r <= {CntW{1'b0}};
            end
        end
    end

    // Tag stage: remembers which port/index the PHY answers in the next cycle.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_r <= 1'b0;
            tag_port_r  <= {PortW{1'b0}};
            tag_idx_r   <= {CntW{1'b0}};
        end else begin
            tag_valid_r <= (state_r == XFER);
            tag_port_r  <= sel_r;
            tag_idx_r   <= cnt_r;
        end
    end

    // Capture mux and SOC framing check; the error restarts at index 0.
    always_comb begin
        cap_data_s = bus.rx_data[int'(tag_port_r) * IfWidth +: IfWidth];
        cap_soc_s  = bus.rx_soc[tag_port_r];
        err_now_s  = (tag_idx_r == {CntW{1'b0}}) ? ~cap_soc_s : cap_soc_s;
        err_acc_s  = (tag_idx_r == {CntW{1'b0}}) ? err_now_s : (err_r | err_now_s);
    end

    // Output register stage; out_soc follows the index, not the PHY SOC.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_soc_r   <= 1'b0;
            out_data_r  <= {IfWidth{1'b0}};
            out_port_r  <= {PortW{1'b0}};
            cell_done_r <= 1'b0;
            cell_err_r  <= 1'b0;
            err_r       <= 1'b0;
        end else if (tag_valid_r) begin
            out_valid_r <= 1'b1;
            out_soc_r   <= (tag_idx_r == {CntW{1'b0}});
            out_data_r  <= cap_data_s;
            out_port_r  <= tag_port_r;
            cell_done_r <= (tag_idx_r == LastIdx);
            cell_err_r  <= (tag_idx_r == LastIdx) & err_acc_s;
            err_r       <= err_acc_s;
        end else begin
            out_valid_r <= 1'b0;
            out_soc_r   <= 1'b0;
            cell_done_r <= 1'b0;
            cell_err_r  <= 1'b0;
        end
    end

    assign bus.rx_en_n   = rx_en_n_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_soc   = out_soc_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_port  = out_port_r;
    assign bus.cell_done = cell_done_r;
    assign bus.cell_err  = cell_err_r;

endmodule

// File: tb/tb_utopia_rx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_utopia_rx_scheduler
// Directed bench for utopia_rx_scheduler. A small PHY model answers each
// enable-low cycle one cycle later with byte p*64+index on port p and a SOC
// on index 0 (fault knobs can drop it or add a spurious one). Outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_utopia_rx_scheduler;
    localparam int NumRx     = 4;
    localparam int IfWidth   = 8;
    localparam int CellBytes = 53;

    logic clk_in = 1'b0;
    logic reset_n;

    always #5 clk_in = ~clk_in;

    utopia_rx_if #(.NumRx(NumRx), .IfWidth(IfWidth)) u_if ();

    utopia_rx_scheduler #(
        .NumRx(NumRx), .IfWidth(IfWidth), .CellBytes(CellBytes)
    ) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .bus    (u_if.master)
    );

    int checks = 0;
    int errors = 0;
    bit drop_soc0 = 1'b0;
    int spur_idx  = -1;
    int phy_idx[NumRx];

    // PHY model: data follows the enable seen in the previous cycle
    initial begin
        logic [NumRx-1:0] en_seen;
        u_if.rx_data = '0;
        u_if.rx_soc  = '0;
        for (int p = 0; p < NumRx; p++) phy_idx[p] = 0;
        forever begin
            @(negedge clk_in);
            en_seen = u_if.rx_en_n;
            @(posedge clk_in);
            #1;
            for (int p = 0; p < NumRx; p++) begin
                if (!en_seen[p]) begin
                    u_if.rx_data[p*IfWidth +: IfWidth] = 8'(p * 64 + phy_idx[p]);
                    u_if.rx_soc[p] = ((phy_idx[p] == 0) && !drop_soc0) || (phy_idx[p] == spur_idx);
                    phy_idx[p]++;
                end else begin
                    u_if.rx_data[p*IfWidth +: IfWidth] = 8'h00;
                    u_if.rx_soc[p] = 1'b0;
                    phy_idx[p] = 0;
                end
            end
        end
    end

    task automatic test_reset;
        reset_n = 1'b0;
        u_if.rx_clav = 4'b0000;
        u_if.core_ready = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (u_if.rx_en_n !== 4'b1111) begin
            errors++; $display("FAIL reset_en got %b want 1111", u_if.rx_en_n);
        end
        checks++;
        if ({u_if.out_valid, u_if.out_soc, u_if.out_data, u_if.out_port,
             u_if.cell_done, u_if.cell_err, u_if.busy} !== 15'd0) begin
            errors++; $display("FAIL reset_outs got v%b s%b d%h p%0d dn%b e%b b%b want all 0",
                u_if.out_valid, u_if.out_soc, u_if.out_data, u_if.out_port,
                u_if.cell_done, u_if.cell_err, u_if.busy);
        end
        reset_n = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_fairness;
        int st_t[6];
        int st_p[6];
        int nst = 0;
        int overlap = 0;
        logic [3:0] prev;
        u_if.rx_clav = 4'b1111;
        u_if.core_ready = 1'b1;
        prev = u_if.rx_en_n;
        for (int cyc = 0; cyc < 400 && nst < 6; cyc++) begin
            @(negedge clk_in);
            if ($countones(~u_if.rx_en_n) > 1) overlap++;
            if (u_if.rx_en_n != 4'b1111 && prev == 4'b1111) begin
                st_t[nst] = cyc;
                for (int p = 0; p < NumRx; p++)
                    if (u_if.rx_en_n[p] == 1'b0) st_p[nst] = p;
                nst++;
                if (nst == 6) u_if.rx_clav = 4'b0000;
            end
            prev = u_if.rx_en_n;
        end
        repeat (60) begin
            @(negedge clk_in);
            if ($countones(~u_if.rx_en_n) > 1) overlap++;
        end
        checks++;
        if (nst != 6) begin
            errors++; $display("FAIL fair_grants got %0d want 6 (timeout)", nst);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (st_p[i] != i % 4) begin
                    errors++; $display("FAIL fair_order[%0d] got %0d want %0d", i, st_p[i], i % 4);
                end
                if (i > 0) begin
                    checks++;
                    if (st_t[i] - st_t[i-1] != 54) begin
                        errors++; $display("FAIL fair_period[%0d] got %0d want 54", i, st_t[i] - st_t[i-1]);
                    end
                end
            end
        end
        checks++;
        if (overlap != 0) begin
            errors++; $display("FAIL fair_onehot got %0d overlaps want 0", overlap);
        end
    endtask

    task automatic test_single;
        int k = 0;
        int en_low = 0;
        int first_en = -1;
        int first_v = -1;
        u_if.rx_clav = 4'b0100;
        u_if.core_ready = 1'b1;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(negedge clk_in);
            if (u_if.rx_en_n == 4'b1011) begin
                if (first_en < 0) first_en = cyc;
                en_low++;
                u_if.rx_clav = 4'b0000;
            end
            if (u_if.out_valid) begin
                if (first_v < 0) first_v = cyc;
                checks++;
                if (u_if.out_data !== 8'(128 + k) || u_if.out_port !== 2'd2 ||
                    u_if.out_soc !== (k == 0) || u_if.cell_done !== (k == CellBytes - 1) ||
                    u_if.cell_err !== 1'b0) begin
                    errors++;
                    $display("FAIL single_byte[%0d] got d%h p%0d s%b dn%b e%b want d%h p2 s%b dn%b e0",
                        k, u_if.out_data, u_if.out_port, u_if.out_soc, u_if.cell_done, u_if.cell_err,
                        8'(128 + k), (k == 0), (k == CellBytes - 1));
                end
                k++;
            end
        end
        checks++;
        if (first_en != 0) begin
            errors++; $display("FAIL single_grant_lat got %0d want 0", first_en);
        end
        checks++;
        if (en_low != 53) begin
            errors++; $display("FAIL single_en_cycles got %0d want 53", en_low);
        end
        checks++;
        if (k != 53) begin
            errors++; $display("FAIL single_bytes got %0d want 53", k);
        end
        checks++;
        if (first_v - first_en != 2) begin
            errors++; $display("FAIL single_data_lat got %0d want 2", first_v - first_en);
        end
    endtask

    task automatic test_backpressure;
        int en_low = 1;
        int nb = 0;
        int bad = 0;
        u_if.rx_clav = 4'b0001;
        u_if.core_ready = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            if (u_if.rx_en_n !== 4'b1111 || u_if.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold got %0d granted cycles want 0", bad);
        end
        u_if.core_ready = 1'b1;
        @(negedge clk_in);
        checks++;
        if (u_if.rx_en_n !== 4'b1110 || u_if.busy !== 1'b1) begin
            errors++; $display("FAIL bp_grant got en%b busy%b want en1110 busy1", u_if.rx_en_n, u_if.busy);
        end
        u_if.core_ready = 1'b0;
        u_if.rx_clav = 4'b0000;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk_in);
            if (u_if.rx_en_n == 4'b1110) en_low++;
            if (u_if.out_valid) nb++;
        end
        checks++;
        if (en_low != 53 || nb != 53) begin
            errors++; $display("FAIL bp_full_cell got en%0d bytes%0d want 53/53", en_low, nb);
        end
    endtask

    task automatic test_framing;
        bit drop_cfg[3];
        int spur_cfg[3];
        bit exp_err[3];
        drop_cfg = '{1'b1, 1'b0, 1'b0};
        spur_cfg = '{-1, -1, 10};
        exp_err  = '{1'b1, 1'b0, 1'b1};
        u_if.core_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            int nb = 0;
            int dn = 0;
            int stray = 0;
            logic err_at_done = 1'b0;
            drop_soc0 = drop_cfg[r];
            spur_idx = spur_cfg[r];
            u_if.rx_clav = 4'b0001;
            for (int cyc = 0; cyc < 130; cyc++) begin
                @(negedge clk_in);
                if (u_if.rx_en_n != 4'b1111) u_if.rx_clav = 4'b0000;
                if (u_if.out_valid) nb++;
                if (u_if.cell_done) begin
                    dn++;
                    err_at_done = u_if.cell_err;
                end
                if (u_if.cell_err && !u_if.cell_done) stray++;
            end
            checks++;
            if (nb != 53 || dn != 1) begin
                errors++; $display("FAIL frame_fwd[%0d] got bytes%0d done%0d want 53/1", r, nb, dn);
            end
            checks++;
            if (err_at_done !== exp_err[r] || stray != 0) begin
                errors++; $display("FAIL frame_err[%0d] got err%b stray%0d want err%b stray0",
                    r, err_at_done, stray, exp_err[r]);
            end
        end
        drop_soc0 = 1'b0;
        spur_idx = -1;
    endtask

    task automatic test_reset_mid_cell;
        int en_low = 0;
        int dn = 0;
        bit hit = 1'b0;
        u_if.rx_clav = 4'b0001;
        u_if.core_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            @(negedge clk_in);
            if (u_if.rx_en_n == 4'b1110) begin
                u_if.rx_clav = 4'b0000;
                if (en_low == 20) begin
                    reset_n = 1'b0;
                    hit = 1'b1;
                end
                en_low++;
            end
        end
        #1;
        checks++;
        if (!hit || u_if.rx_en_n !== 4'b1111 || u_if.out_valid !== 1'b0 || u_if.busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async got hit%b en%b v%b busy%b want 1 1111 0 0",
                hit, u_if.rx_en_n, u_if.out_valid, u_if.busy);
        end
        repeat (3) begin
            @(negedge clk_in);
            if (u_if.cell_done) dn++;
        end
        reset_n = 1'b1;
        repeat (60) begin
            @(negedge clk_in);
            if (u_if.cell_done) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++; $display("FAIL rst_mid_no_done got %0d want 0", dn);
        end
        u_if.rx_clav = 4'b1010;
        @(negedge clk_in);
        checks++;
        if (u_if.rx_en_n !== 4'b1101) begin
            errors++; $display("FAIL rst_ptr_grant got %b want 1101", u_if.rx_en_n);
        end
        u_if.rx_clav = 4'b0000;
        repeat (60) @(negedge clk_in);
    endtask

    task automatic test_clav_drop;
        int en_low = 0;
        int k = 0;
        int bad = 0;
        int dn = 0;
        logic err_at_done = 1'b0;
        u_if.rx_clav = 4'b0100;
        u_if.core_ready = 1'b1;
        for (int cyc = 0; cyc < 130; cyc++) begin
            @(negedge clk_in);
            if (u_if.rx_en_n == 4'b1011) begin
                if (en_low == 5) u_if.rx_clav = 4'b0000;
                en_low++;
            end
            if (u_if.out_valid) begin
                if (u_if.out_data !== 8'(128 + k) || u_if.out_port !== 2'd2) bad++;
                k++;
            end
            if (u_if.cell_done) begin
                dn++;
                err_at_done = u_if.cell_err;
            end
        end
        checks++;
        if (en_low != 53 || k != 53) begin
            errors++; $display("FAIL clav_drop_len got en%0d bytes%0d want 53/53", en_low, k);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL clav_drop_data got %0d bad bytes want 0", bad);
        end
        checks++;
        if (dn != 1 || err_at_done !== 1'b0) begin
            errors++; $display("FAIL clav_drop_done got done%0d err%b want 1/0", dn, err_at_done);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        u_if.rx_clav = 4'b0000;
        u_if.core_ready = 1'b0;
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_framing();
        test_reset_mid_cell();
        test_clav_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
